// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N-channel programmable 50%-duty clock divider with glitch-free divisor reload
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*CNT_W-1:0] div_num,
  output logic [CHANNELS-1:0]       sclk,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       pend
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] act_div_q, act_div_d, pend_div_q, pend_div_d, cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d, sclk_q, sclk_d, rise_q, rise_d;
    logic             idle, bnd, apply;
    always_comb begin
      idle       = sync | ~en[c] | (act_div_q == '0);
      bnd        = ~idle & (cnt_q >= act_div_q);
      apply      = pend_v_q & (idle | bnd);
      act_div_d  = apply ? pend_div_q : act_div_q;
      pend_div_d = load[c] ? div_num[c*CNT_W +: CNT_W] : pend_div_q;
      pend_v_d   = load[c] | (pend_v_q & ~apply);
      cnt_d      = (idle | bnd) ? '0 : cnt_q + 1'b1;
      // a divisor of 0 taking effect at a boundary parks the clock low without a stray pulse
      sclk_d     = idle ? 1'b0 : bnd ? (~sclk_q & (act_div_d != '0)) : sclk_q;
      rise_d     = sclk_d & ~sclk_q;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        act_div_q  <= '0;
        pend_div_q <= '0;
        pend_v_q   <= 1'b0;
        cnt_q      <= '0;
        sclk_q     <= 1'b0;
        rise_q     <= 1'b0;
      end else begin
        act_div_q  <= act_div_d;
        pend_div_q <= pend_div_d;
        pend_v_q   <= pend_v_d;
        cnt_q      <= cnt_d;
        sclk_q     <= sclk_d;
        rise_q     <= rise_d;
      end
    end
    assign sclk[c] = sclk_q;
    assign rise[c] = rise_q;
    assign pend[c] = pend_v_q;
  end
endmodule
